regfile_bus: RTL

Parametrised multi-register file for the 4-bit microcode processor datapath, generalising the single bus-attached register into DEPTH registers of WIDTH bits. Each register can be loaded from the instruction immediate or from the shared tri-state BUS, and one selected register can drive the BUS. Optional increment/decrement with registered zero/carry flags. Sits between the microcode sequencer (control strobes) and the shared BUS.

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_cell.sv | 25 ++
 rtl/regfile_bus.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared constants and types for the bus-attached register file.
//
// Contents:
//   DEF_WIDTH / DEF_DEPTH / DEF_RESET_VAL : default geometry and reset value
//   wr_src_e                              : write source chosen by the priority encoder
//   strobe_count()                        : number of write strobes raised in a cycle
//
// Optional feature macro used by the design: REGFILE_INCDEC_EN.
package regfile_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_RESET_VAL = 0;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_IMM  = 3'd1,
    SRC_BUS  = 3'd2,
    SRC_INC  = 3'd3,
    SRC_DEC  = 3'd4
  } wr_src_e;

  // Strobe vector ordering: {dec, inc, bus_ld, imm_ld}.
  function automatic logic [2:0] strobe_count(input logic [3:0] s);
    return {2'b00, s[0]} + {2'b00, s[1]} + {2'b00, s[2]} + {2'b00, s[3]};
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// regfile_cell -- one WIDTH-bit storage register with write enable.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, loads RESET_VAL
//   we   : write enable
//   d    : write data
//   q    : stored value
module regfile_cell #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= RESET_VAL;
    else if (we) q <= d;
  end

endmodule

// File: rtl/regfile_bus.sv
// regfile_bus -- DEPTH x WIDTH register file attached to a shared tri-state BUS.
//
// Each register loads from the immediate or from the BUS; one register can
// drive the BUS. Optional increment/decrement (macro REGFILE_INCDEC_EN) with
// carry/borrow flag. Without the macro inc/dec are ignored and cf is tied 0.
//
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   im              : immediate operand
//   wr_addr/rd_addr : write target / BUS source register
//   imm_ld, bus_ld  : load from im / from bus (imm_ld wins)
//   bus_oe          : drive reg[rd_addr] onto bus
//   inc, dec        : +1 / -1 on reg[wr_addr] (lowest priorities)
//   bus             : shared tri-state BUS
//   zf, cf          : zero / carry flags of the last executed write
//   err             : sticky control error (multi-strobe or bad address)
module regfile_bus
  import regfile_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL),
  localparam int              AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] im,
  input  logic [AW-1:0]    wr_addr,
  input  logic [AW-1:0]    rd_addr,
  input  logic             imm_ld,
  input  logic             bus_ld,
  input  logic             bus_oe,
  input  logic             inc,
  input  logic             dec,
  inout  wire  [WIDTH-1:0] bus,
  output logic             zf,
  output logic             cf,
  output logic             err
);

  logic [DEPTH-1:0][WIDTH-1:0] q_arr;
  logic [3:0]                  strb;
  wr_src_e                     src;
  logic                        wr_ok, rd_ok, wr_do, drive_en, err_set;
  logic [AW-1:0]               wr_idx, rd_idx;
  logic [WIDTH-1:0]            rd_data, cur, nxt, bus_in;
  logic                        nxt_cf;

`ifdef REGFILE_INCDEC_EN
  assign strb = {dec, inc, bus_ld, imm_ld};
`else
  // inc/dec exist for pin compatibility only.
  logic unused_incdec;
  assign unused_incdec = inc ^ dec;
  assign strb          = {2'b00, bus_ld, imm_ld};
`endif

  // Addresses can exceed DEPTH-1 only when DEPTH is not a power of two.
  assign wr_ok  = {1'b0, wr_addr} < (AW+1)'(DEPTH);
  assign rd_ok  = {1'b0, rd_addr} < (AW+1)'(DEPTH);
  // Clamp indices so an illegal address never selects outside the array.
  assign wr_idx = wr_ok ? wr_addr : '0;
  assign rd_idx = rd_ok ? rd_addr : '0;

  assign rd_data = q_arr[rd_idx];
  assign cur     = q_arr[wr_idx];

  // Drive is gated by rst so the bus releases the instant reset asserts.
  assign drive_en = rst & bus_oe & rd_ok;
  assign bus      = drive_en ? rd_data : {WIDTH{1'bz}};
  // When we drive, load our own value rather than the resolved net.
  assign bus_in   = drive_en ? rd_data : bus;

  always_comb begin
    src = SRC_NONE;
    if      (strb[0]) src = SRC_IMM;
    else if (strb[1]) src = SRC_BUS;
    else if (strb[2]) src = SRC_INC;
    else if (strb[3]) src = SRC_DEC;
  end

  assign wr_do = (src != SRC_NONE) && wr_ok;

  always_comb begin
    nxt    = cur;
    nxt_cf = 1'b0;
    case (src)
      SRC_IMM: nxt = im;
      SRC_BUS: nxt = bus_in;
`ifdef REGFILE_INCDEC_EN
      SRC_INC: begin
        nxt    = cur + 1'b1;
        nxt_cf = &cur;
      end
      SRC_DEC: begin
        nxt    = cur - 1'b1;
        nxt_cf = ~|cur;
      end
`endif
      default: nxt = cur;
    endcase
  end

  assign err_set = (strobe_count(strb) > 3'd1)
                 | ((src != SRC_NONE) & ~wr_ok)
                 | (bus_oe & ~rd_ok);

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    regfile_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .we  (wr_do && (wr_addr == AW'(i))),
      .d   (nxt),
      .q   (q_arr[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zf  <= 1'b0;
      err <= 1'b0;
    end else begin
      if (err_set) err <= 1'b1;
      if (wr_do)   zf  <= (nxt == '0);
    end
  end

`ifdef REGFILE_INCDEC_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cf <= 1'b0;
    else if (wr_do) cf <= nxt_cf;
  end
`else
  assign cf = 1'b0;
`endif

endmodule
